// File: rtl/vend_host_driver_if.sv
// Machine-side bus between the purchase host and the vending machine.
// master: host drives card/key/pay/door, machine returns vend/cost/status.
interface vend_host_driver_if;
  logic       CARD_IN;
  logic [3:0] ITEM_CODE;
  logic       KEY_PRESS;
  logic       VALID_TRAN;
  logic       DOOR_OPEN;
  logic       VEND;
  logic       INVALID_SEL;
  logic [2:0] COST;
  logic       FAILED_TRAN;

  modport master (
    output CARD_IN, ITEM_CODE, KEY_PRESS,
    output VALID_TRAN, DOOR_OPEN,
    input  VEND, INVALID_SEL, COST, FAILED_TRAN
  );

  modport slave (
    input  CARD_IN, ITEM_CODE, KEY_PRESS,
    input  VALID_TRAN, DOOR_OPEN,
    output VEND, INVALID_SEL, COST, FAILED_TRAN
  );
endinterface

// File: rtl/vend_host_driver.sv
// Purchase host: card, two key digits, cost check, pay/decline, door.
// Ports: CLK/RESET, START/TENS/ONES, LOAD_BAL/BAL_IN, mach bus, BUSY/DONE/STATUS/BALANCE.
module vend_host_driver #(
  parameter int KEY_GAP     = 1,
  parameter int COST_WAIT   = 2,
  parameter int TIMEOUT     = 8,
  parameter int DOOR_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [3:0] TENS,
  input  logic [3:0] ONES,
  input  logic       LOAD_BAL,
  input  logic [7:0] BAL_IN,
  vend_host_driver_if.master mach,
  output logic       BUSY,
  output logic       DONE,
  output logic [1:0] STATUS,
  output logic [7:0] BALANCE
);

  typedef enum logic [3:0] {
    IDLE, CARD, KEY1, GAP1, KEY2, GAP2, CWAIT,
    PAY, DECL, VWAIT, DOPEN, DCLOSE, FIN
  } state_t;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_INV  = 2'd1;
  localparam logic [1:0] ST_DECL = 2'd2;
  localparam logic [1:0] ST_NOV  = 2'd3;

  localparam logic [3:0] GAP_LAST  = 4'(KEY_GAP - 1);
  localparam logic [3:0] CW_LAST   = 4'(COST_WAIT - 1);
  localparam logic [3:0] TO_LAST   = 4'(TIMEOUT - 1);
  localparam logic [3:0] DOOR_LAST = 4'(DOOR_CYCLES - 1);

  state_t     state;
  logic [3:0] timer;
  logic [3:0] tens_q;
  logic [3:0] ones_q;
  logic [2:0] cost_q;
  logic       card_in;
  logic       key_press;
  logic       valid_tran;
  logic       door_open;
  logic [3:0] item_code;

  assign mach.CARD_IN    = card_in;
  assign mach.ITEM_CODE  = item_code;
  assign mach.KEY_PRESS  = key_press;
  assign mach.VALID_TRAN = valid_tran;
  assign mach.DOOR_OPEN  = door_open;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      timer      <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      cost_q     <= '0;
      card_in    <= 1'b0;
      key_press  <= 1'b0;
      valid_tran <= 1'b0;
      door_open  <= 1'b0;
      item_code  <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      STATUS     <= ST_OK;
      BALANCE    <= '0;
    end else begin
      // every state change below also clears the timer
      timer <= timer + 4'd1;
      unique case (state)
        IDLE: begin
          timer <= '0;
          if (LOAD_BAL) BALANCE <= BAL_IN;
          if (START) begin
            tens_q  <= TENS;
            ones_q  <= ONES;
            STATUS  <= ST_OK;
            BUSY    <= 1'b1;
            card_in <= 1'b1;
            state   <= CARD;
          end
        end
        CARD: begin
          timer     <= '0;
          card_in   <= 1'b0;
          item_code <= tens_q;
          key_press <= 1'b1;
          state     <= KEY1;
        end
        KEY1: begin
          timer     <= '0;
          key_press <= 1'b0;
          if (mach.INVALID_SEL) begin
            item_code <= '0;
            STATUS    <= ST_INV;
            DONE      <= 1'b1;
            state     <= FIN;
          end else begin
            state <= GAP1;
          end
        end
        GAP1: begin
          if (mach.INVALID_SEL) begin
            timer     <= '0;
            item_code <= '0;
            STATUS    <= ST_INV;
            DONE      <= 1'b1;
            state     <= FIN;
          end else if (timer == GAP_LAST) begin
            timer     <= '0;
            item_code <= ones_q;
            key_press <= 1'b1;
            state     <= KEY2;
          end
        end
        KEY2: begin
          timer     <= '0;
          key_press <= 1'b0;
          if (mach.INVALID_SEL) begin
            item_code <= '0;
            STATUS    <= ST_INV;
            DONE      <= 1'b1;
            state     <= FIN;
          end else begin
            state <= GAP2;
          end
        end
        GAP2: begin
          if (mach.INVALID_SEL) begin
            timer     <= '0;
            item_code <= '0;
            STATUS    <= ST_INV;
            DONE      <= 1'b1;
            state     <= FIN;
          end else if (timer == GAP_LAST) begin
            timer     <= '0;
            item_code <= '0;
            state     <= CWAIT;
          end
        end
        CWAIT: begin
          if (mach.INVALID_SEL) begin
            timer  <= '0;
            STATUS <= ST_INV;
            DONE   <= 1'b1;
            state  <= FIN;
          end else if (timer == CW_LAST) begin
            timer  <= '0;
            cost_q <= mach.COST;
            // a zero cost means the machine rejected the code
            if (mach.COST == 3'd0) begin
              STATUS <= ST_INV;
              DONE   <= 1'b1;
              state  <= FIN;
            end else if (BALANCE >= {5'd0, mach.COST}) begin
              valid_tran <= 1'b1;
              state      <= PAY;
            end else begin
              state <= DECL;
            end
          end
        end
        PAY: begin
          timer      <= '0;
          valid_tran <= 1'b0;
          BALANCE    <= BALANCE - {5'd0, cost_q};
          state      <= VWAIT;
        end
        DECL: begin
          if (mach.FAILED_TRAN || timer == TO_LAST) begin
            timer  <= '0;
            STATUS <= ST_DECL;
            DONE   <= 1'b1;
            state  <= FIN;
          end
        end
        VWAIT: begin
          if (mach.VEND) begin
            timer     <= '0;
            door_open <= 1'b1;
            state     <= DOPEN;
          end else if (timer == TO_LAST) begin
            timer  <= '0;
            STATUS <= ST_NOV;
            DONE   <= 1'b1;
            state  <= FIN;
          end
        end
        DOPEN: begin
          if (timer == DOOR_LAST) begin
            timer     <= '0;
            door_open <= 1'b0;
            state     <= DCLOSE;
          end
        end
        DCLOSE: begin
          if (!mach.VEND) begin
            timer  <= '0;
            STATUS <= ST_OK;
            DONE   <= 1'b1;
            state  <= FIN;
          end else if (timer == TO_LAST) begin
            timer  <= '0;
            STATUS <= ST_NOV;
            DONE   <= 1'b1;
            state  <= FIN;
          end
        end
        FIN: begin
          timer <= '0;
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          timer <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vend_host_driver.md
Name: vend_host_driver

Overview:
- Purchase-side initiator for the vending machine FSM. It plays the card-holder/payment terminal: asserts CARD_IN, keys two item digits, reads back COST, authorises or declines payment from an internal balance, then opens and closes the door.
- Used as a stimulus/host block on the board and in system benches, wired port-to-port against the vending machine.

Parameters:
KEY_GAP, 1, idle cycles with KEY_PRESS low between and after each key press (1..7)
COST_WAIT, 2, cycles after the second key release before COST is sampled (1..7)
TIMEOUT, 8, max cycles waiting for VEND assert, VEND deassert, or FAILED_TRAN (2..15)
DOOR_CYCLES, 2, cycles DOOR_OPEN is held high (1..7)

Ports:
CLK  in  1  clock; all logic on posedge
RESET  in  1  synchronous, active-high reset
START  in  1  one-cycle purchase request; honoured only in IDLE
TENS  in  4  first item digit; latched on accepted START
ONES  in  4  second item digit; latched on accepted START
LOAD_BAL  in  1  load BAL_IN into BALANCE; honoured only in IDLE
BAL_IN  in  8  credit value to load
VEND  in  1  from machine
INVALID_SEL  in  1  from machine
COST  in  3  from machine
FAILED_TRAN  in  1  from machine
CARD_IN  out  1  to machine
ITEM_CODE  out  4  to machine
KEY_PRESS  out  1  to machine
VALID_TRAN  out  1  to machine
DOOR_OPEN  out  1  to machine
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse at the end of a purchase
STATUS  out  2  result: 0 OK, 1 INVALID, 2 DECLINED, 3 NO_VEND
BALANCE  out  8  current credit

Behaviour:
- Reset is RESET, synchronous, active-high; clock is CLK. RESET dominates in every state, including mid-purchase.
- Reset values: all outputs 0, BALANCE 0, STATUS 0, state IDLE.
- All outputs are registered. Inputs are sampled on the posedge.
- States: IDLE, CARD, KEY1, GAP1, KEY2, GAP2, CWAIT, PAY, DECL, VWAIT, DOPEN, DCLOSE, FIN.
- IDLE:
  - LOAD_BAL: BALANCE <= BAL_IN.
  - START: latch TENS and ONES, go to CARD. If START and LOAD_BAL arrive in the same cycle, the load is applied and the purchase uses the new balance.
  - START while BUSY is ignored and is not queued.
- CARD: CARD_IN=1 for exactly one cycle, then KEY1.
- KEY1: ITEM_CODE=tens digit, KEY_PRESS=1 for one cycle, then GAP1.
- GAP1: KEY_PRESS=0 and ITEM_CODE held for KEY_GAP cycles, then KEY2.
- KEY2 / GAP2: same as KEY1 / GAP1 with the ones digit, then CWAIT.
- INVALID_SEL is sampled in KEY1, GAP1, KEY2, GAP2 and CWAIT. Any high sample sends the FSM to FIN with STATUS=1.
- CWAIT:
  - Lasts COST_WAIT cycles; COST is latched on the last cycle.
  - Latched COST = 0: FIN, STATUS=1.
  - BALANCE >= COST (8-bit unsigned compare, COST zero-extended): PAY.
  - Otherwise: DECL.
- PAY: VALID_TRAN=1 for one cycle; BALANCE <= BALANCE − COST (never underflows). Then VWAIT.
- DECL:
  - VALID_TRAN held 0.
  - Wait for FAILED_TRAN or TIMEOUT cycles, whichever comes first.
  - Then FIN, STATUS=2; BALANCE is unchanged.
- VWAIT:
  - Wait for VEND=1, then DOPEN.
  - If VEND is not seen within TIMEOUT cycles: FIN, STATUS=3. BALANCE is not refunded.
- DOPEN: DOOR_OPEN=1 for DOOR_CYCLES cycles, then DCLOSE.
- DCLOSE:
  - DOOR_OPEN=0; wait for VEND=0.
  - VEND drops within TIMEOUT cycles: FIN, STATUS=0.
  - VEND still high after TIMEOUT cycles: FIN, STATUS=3.
- FIN: DONE=1 for one cycle, then IDLE.
  - STATUS holds until the next accepted START, which clears it to 0.
- CARD_IN, KEY_PRESS, VALID_TRAN and DOOR_OPEN are never high outside their own states.
- ITEM_CODE reads 0 outside KEY1/GAP1/KEY2/GAP2.
- Timer: one shared counter, cleared on every state change, 4 bits wide.

Test Plan:
- BAL_IN=10 loaded; START with 0,5; bench machine returns COST=2, then VEND high 4 cycles after VALID_TRAN and low after the door closes -> exactly one VALID_TRAN pulse, DOOR_OPEN high for 2 cycles, DONE pulse, STATUS=0, BALANCE=8.
- BAL_IN=3; START with 1,9; COST=6 -> VALID_TRAN never high; FAILED_TRAN at cycle 5 of DECL -> STATUS=2, BALANCE=3. Repeat with no FAILED_TRAN -> DONE after 8 DECL cycles.
- START with 2,0; bench drives INVALID_SEL in GAP1 -> no KEY_PRESS for the second digit, STATUS=1, BALANCE unchanged.
- Valid purchase, VEND never asserted -> DONE 8 cycles into VWAIT, STATUS=3, BALANCE already debited.
- RESET held one cycle while in DOPEN -> next cycle all outputs 0, BALANCE=0, BUSY=0. START during BUSY -> ignored, no second CARD_IN.
- LOAD_BAL=1, BAL_IN=6 in the same cycle as START with 1,9 and COST=6 -> PAY taken, BALANCE=0, STATUS=0.
